// File: rtl/rot_pkg.sv
// Shared constants and helpers for the rotary-encoder input filter.
// Channel indices, synthesis debounce default and the counter-width helper.
package rot_pkg;

  localparam int NUM_CH    = 3;
  localparam int CH_A      = 0;
  localparam int CH_B      = 1;
  localparam int CH_CENTER = 2;

  // 10 ms at 50 MHz; simulation builds override this with a small value.
  localparam int DEBOUNCE_SYNTH = 500_000;

  localparam int GLITCH_CNT_W = 8;

  // The counter must be able to hold DEBOUNCE_CYCLES-1, with a 1-bit floor.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return (($clog2(cycles + 1)) < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/rot_input_filter_if.sv
// Pin-side and filtered-side signals of the rotary-encoder input filter.
// Optional `glitches` member exists only with ROT_INPUT_FILTER_GLITCH_CNT_EN.
interface rot_input_filter_if;

  logic rota_in;
  logic rotb_in;
  logic center_in;
  logic rota;
  logic rotb;
  logic center;
  logic center_press;
  logic center_release;
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
  logic [7:0] glitches;
`endif

  modport master (
    output rota_in, rotb_in, center_in,
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
    input  glitches,
`endif
    input  rota, rotb, center, center_press, center_release
  );

  modport slave (
    input  rota_in, rotb_in, center_in,
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
    output glitches,
`endif
    output rota, rotb, center, center_press, center_release
  );

endinterface

// File: rtl/rot_debounce_channel.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a
// stable-level debouncer. Glitch pulse only with ROT_INPUT_FILTER_GLITCH_CNT_EN.
module rot_debounce_channel
  import rot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic accept
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   stable_q;
  logic [CNT_W-1:0]       cnt_q;

  // Plain flop chain; the first stage may go metastable, later ones settle it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is taken on the edge where it has persisted long enough.
  assign accept = (s != stable_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (s == stable_q) begin
      cnt_q    <= '0;
    end else if (accept) begin
      stable_q <= s;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign level = stable_q;

`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
  // A pending change abandoned because s fell back to the stable level.
  assign glitch = (s == stable_q) && (cnt_q != '0);
`endif

endmodule

// File: rtl/rot_input_filter.sv
// Input conditioning for the rotary encoder (A, B) and push button (center).
// Optional glitch counter output enabled by ROT_INPUT_FILTER_GLITCH_CNT_EN.
module rot_input_filter
  import rot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  rot_input_filter_if.slave bus
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] accept;
  logic              press_q;
  logic              release_q;
  logic              unused_accept;
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
  logic [NUM_CH-1:0]       glitch;
  logic [1:0]              glitch_sum;
  logic [GLITCH_CNT_W:0]   glitch_next;
  logic [GLITCH_CNT_W-1:0] glitch_q;
`endif

  assign raw[CH_A]      = bus.rota_in;
  assign raw[CH_B]      = bus.rotb_in;
  assign raw[CH_CENTER] = bus.center_in;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rot_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .din    (raw[ch]),
      .level  (level[ch]),
      .accept (accept[ch])
`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
      ,
      .glitch (glitch[ch])
`endif
    );
  end

  // Encoder channels only need their levels; the accept pulse drives strobes.
  assign unused_accept = accept[CH_A] ^ accept[CH_B];

  // Registered off the accept pulse so the strobe lines up with the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= accept[CH_CENTER] & ~level[CH_CENTER];
      release_q <= accept[CH_CENTER] &  level[CH_CENTER];
    end
  end

  assign bus.rota           = level[CH_A];
  assign bus.rotb           = level[CH_B];
  assign bus.center         = level[CH_CENTER];
  assign bus.center_press   = press_q;
  assign bus.center_release = release_q;

`ifdef ROT_INPUT_FILTER_GLITCH_CNT_EN
  assign glitch_sum  = 2'(glitch[CH_A]) + 2'(glitch[CH_B]) + 2'(glitch[CH_CENTER]);
  assign glitch_next = {1'b0, glitch_q} + {{(GLITCH_CNT_W - 1){1'b0}}, glitch_sum};

  // Saturating so a noisy board pins the debug LEDs rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_q <= '0;
    end else if (glitch_next[GLITCH_CNT_W]) begin
      glitch_q <= '1;
    end else begin
      glitch_q <= glitch_next[GLITCH_CNT_W-1:0];
    end
  end

  assign bus.glitches = glitch_q;
`endif

endmodule
